// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, owner select and access sizes.
package sram_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_WAIT = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Data always wins a same-cycle collision with instruction fetch.
    function automatic logic pick_owner(input logic data_req);
        if (data_req) begin
            return OWN_DATA;
        end else begin
            return OWN_INST;
        end
    endfunction

endpackage

// File: rtl/sram_port_arbiter_req_mux.sv
// Combinational owner-select of the memory request payload and demux of the
// addr_ok/data_ok handshakes back to the owning requester.
module sram_req_mux
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              req_phase,
    input  logic              rsp_phase,
    input  logic              owner,
    input  logic              inst_ok_en,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata
);

    // Request payload: only driven while a request is being presented.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (req_phase) begin
            mem_req = 1'b1;
            if (owner == OWN_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size = SIZE_W;
                mem_addr = inst_addr;
            end
        end else begin
            mem_req = 1'b0;
        end
    end

    // Handshake demux; a cancelled fetch sees neither its accept nor its response.
    always_comb begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (owner == OWN_DATA) begin
            data_addr_ok = req_phase & mem_addr_ok;
            data_data_ok = rsp_phase & mem_data_ok;
        end else begin
            inst_addr_ok = req_phase & mem_addr_ok & inst_ok_en;
            inst_data_ok = rsp_phase & mem_data_ok & inst_ok_en;
        end
    end

    // Read data is only exposed alongside its data_ok.
    always_comb begin
        inst_rdata = {DATA_W{1'b0}};
        data_rdata = {DATA_W{1'b0}};
        if (inst_data_ok) begin
            inst_rdata = mem_rdata;
        end else begin
            inst_rdata = {DATA_W{1'b0}};
        end
        if (data_data_ok) begin
            data_rdata = mem_rdata;
        end else begin
            data_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like port between instruction fetch
// and data access; flush cancels an in-flight fetch by swallowing its response.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       discard_q, discard_d;
    logic       inst_flush_s;
    logic       inst_ok_en_s;

    assign inst_flush_s = flush & (owner_q == OWN_INST);
    assign inst_ok_en_s = ~discard_q & ~flush;

    // Next-state, owner and discard logic; grants are made only from IDLE.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        discard_d = discard_q;
        case (state_q)
            ARB_IDLE: begin
                discard_d = 1'b0;
                if (data_req | inst_req) begin
                    owner_d = pick_owner(data_req);
                    state_d = ARB_REQ;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_REQ: begin
                if (inst_flush_s) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
                if (mem_addr_ok) begin
                    state_d = ARB_WAIT;
                end else begin
                    state_d = ARB_REQ;
                end
            end
            ARB_WAIT: begin
                if (mem_data_ok) begin
                    state_d   = ARB_IDLE;
                    discard_d = 1'b0;
                end else if (inst_flush_s) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                owner_d   = OWN_INST;
                discard_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_INST;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            discard_q <= discard_d;
        end
    end

    sram_req_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_mux (
        .req_phase    (state_q == ARB_REQ),
        .rsp_phase    (state_q == ARB_WAIT),
        .owner        (owner_q),
        .inst_ok_en   (inst_ok_en_s),
        .inst_addr    (inst_addr),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: hand-computed expectations checked with
// immediate assertions after each step.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_req"},      {31'd0, mem_req},      32'd0);
        chk({tag, " mem_addr"},     mem_addr,              32'd0);
        chk({tag, " mem_wdata"},    mem_wdata,             32'd0);
        chk({tag, " mem_ctl"},      {25'd0, mem_wr, mem_size, mem_wstrb}, 32'd0);
        chk({tag, " handshakes"},   {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        chk_quiet("reset");
        reset = 1'b1;

        // Single load
        data_req = 1'b1; data_addr = 32'h0000_1000; data_size = 2'd2; #1;
        chk("load idle latency", {31'd0, mem_req}, 32'd0);
        tick();
        chk("load mem_req", {31'd0, mem_req}, 32'd1);
        chk("load mem_addr", mem_addr, 32'h0000_1000);
        chk("load mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, 1'b0, 2'd2, 4'd0});
        mem_addr_ok = 1'b1; #1;
        chk("load addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0; #1;
        chk("load wait mem_req", {30'd0, mem_req, data_addr_ok}, 32'd0);
        tick();
        chk("load no early data_ok", {31'd0, data_data_ok}, 32'd0);
        mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("load data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd2);
        chk("load rdata", data_rdata, 32'hDEAD_BEEF);
        tick();
        mem_data_ok = 1'b0; #1;
        chk_quiet("load idle");

        // Collision: data store first, then instruction fetch
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b0011;
        data_addr = 32'h0000_2000; data_wdata = 32'h0000_1234;
        tick();
        chk("coll store addr", mem_addr, 32'h0000_2000);
        chk("coll store wdata", mem_wdata, 32'h0000_1234);
        chk("coll store ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, 1'b1, 2'd1, 4'b0011});
        mem_addr_ok = 1'b1; #1;
        chk("coll store addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; #1;
        chk("coll store done", {30'd0, data_data_ok, inst_data_ok}, 32'd2);
        tick();
        mem_data_ok = 1'b0; #1;
        chk("coll idle gap", {31'd0, mem_req}, 32'd0);
        tick();
        chk("coll fetch addr", mem_addr, 32'hBFC0_0100);
        chk("coll fetch ctl", {24'd0, mem_req, mem_wr, mem_size, mem_wstrb}, {24'd0, 1'b1, 1'b0, 2'd2, 4'd0});
        chk("coll fetch wdata", mem_wdata, 32'd0);
        mem_addr_ok = 1'b1; #1;
        chk("coll fetch addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_BFC0; #1;
        chk("coll fetch data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        chk("coll fetch rdata", inst_rdata, 32'h3C1D_BFC0);
        tick();
        mem_data_ok = 1'b0;

        // Flush while waiting for a fetch response
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        tick();
        mem_addr_ok = 1'b1; #1;
        chk("fw addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; flush = 1'b1; #1;
        chk("fw flush cycle", {31'd0, inst_data_ok}, 32'd0);
        tick();
        flush = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222; #1;
        chk("fw discarded", {31'd0, inst_data_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b0; #1;
        chk_quiet("fw idle");
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        tick();
        chk("fw next addr", mem_addr, 32'hBFC0_0004);
        mem_addr_ok = 1'b1; #1;
        chk("fw next addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h2400_0001; #1;
        chk("fw next data_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("fw next rdata", inst_rdata, 32'h2400_0001);
        tick();
        mem_data_ok = 1'b0;

        // Flush in REQ while memory stalls addr_ok for 3 cycles
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        tick();
        flush = 1'b1; #1;
        chk("fr stall1", {30'd0, mem_req, inst_addr_ok}, 32'd2);
        tick();
        flush = 1'b0; inst_req = 1'b0; #1;
        chk("fr stall2", {30'd0, mem_req, inst_addr_ok}, 32'd2);
        tick();
        chk("fr stall3", {30'd0, mem_req, inst_addr_ok}, 32'd2);
        mem_addr_ok = 1'b1; #1;
        chk("fr accept suppressed", {30'd0, mem_req, inst_addr_ok}, 32'd2);
        tick();
        mem_addr_ok = 1'b0; #1;
        chk("fr wait mem_req", {31'd0, mem_req}, 32'd0);
        mem_data_ok = 1'b1; mem_rdata = 32'h3333_4444; #1;
        chk("fr discarded", {31'd0, inst_data_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b0; #1;
        chk_quiet("fr idle");

        // Flush coinciding with a data load response
        data_req = 1'b1; data_addr = 32'h0000_3000; data_size = 2'd2;
        tick();
        mem_addr_ok = 1'b1; #1;
        chk("fd addr_ok", {31'd0, data_addr_ok}, 32'd1);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D; flush = 1'b1; #1;
        chk("fd data_ok", {31'd0, data_data_ok}, 32'd1);
        chk("fd rdata", data_rdata, 32'hCAFE_F00D);
        tick();
        flush = 1'b0; mem_data_ok = 1'b0;

        // Reset in the middle of a WAIT
        inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
        tick();
        mem_addr_ok = 1'b1;
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1; #1;
        chk_quiet("rst mid-wait");
        mem_data_ok = 1'b1; mem_rdata = 32'h5555_6666; #1;
        chk("rst stray response", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b0; #1;
        chk("rst still idle", {31'd0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM-like memory port between the IF-stage instruction requester and the EX/MEM data requester.
- Exactly one transaction is outstanding at a time, with data having priority over instruction.
- Feeds the MEM stage its load data (`data_rdata`) and the IF stage its instruction word.
- A `flush` input (exception or ERET from WB) cancels an in-flight instruction fetch by discarding its response. Data transactions are never cancelled.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low: state is cleared on a rising clk edge while reset==0.
- flush  in  1  single-cycle pulse from WB on exception or ERET.
- inst_req  in  1  instruction read request.
- inst_addr  in  32  instruction address.
- inst_addr_ok  out  1  instruction request accepted.
- inst_data_ok  out  1  instruction data valid.
- inst_rdata  out  32  instruction word.
- data_req  in  1  data request.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  4  byte write enables (for partial stores and SWL/SWR).
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  load data valid or store done.
- data_rdata  out  32  load data, raw word.
- mem_req  out  1  request to memory.
- mem_wr  out  1  write flag.
- mem_size  out  2  access size.
- mem_wstrb  out  4  byte write enables.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory response.
- mem_rdata  in  32  memory read data.

Behaviour:
- Requester protocol: each requester holds its req and payload stable from assertion until its addr_ok is seen. The arbiter does not latch the payload; it latches only the owner.
- States: IDLE, REQ, WAIT. Registers: `owner` (0 = inst, 1 = data) and `discard`.
- IDLE:
  - If data_req, then owner<=1 and go to REQ.
  - Else if inst_req, then owner<=0 and go to REQ.
  - No mem_req is driven in IDLE, so there is 1 cycle of arbitration latency.
- REQ:
  - mem_req=1. mem_wr, mem_size, mem_wstrb, mem_addr and mem_wdata are muxed combinationally from the owner's inputs.
  - For an inst owner: mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.
  - When mem_addr_ok=1: the owner's addr_ok=1 in the same cycle, and the state goes to WAIT.
- WAIT:
  - mem_req=0.
  - When mem_data_ok=1: the owner's data_ok=1 in the same cycle, with rdata passed through combinationally. The state goes to IDLE and discard<=0.
  - A new grant is made only from IDLE, so back-to-back transactions are spaced by at least 3 cycles.
- Flush:
  - Inst owner in REQ: the memory request is still completed (mem_req is not dropped mid-handshake), but inst_addr_ok is suppressed and discard<=1.
  - Inst owner in WAIT: discard<=1.
  - While discard=1, inst_data_ok is forced to 0 and the response is consumed silently.
  - Flush has no effect on data transactions or in IDLE.
- Simultaneous mem_data_ok and flush in WAIT: the response is discarded. Flush wins.
- Simultaneous inst_req and data_req in IDLE: data is granted; inst waits.
- Reset (reset==0 at a clock edge) forces state=IDLE, owner=0 and discard=0, including mid-transaction; an outstanding memory response is then ignored. In IDLE, all outputs are 0: mem_req, both addr_ok, both data_ok, and mem_addr/wdata/wstrb/size/wr.
- A mem_data_ok outside WAIT is ignored; no data_ok is produced.
- inst_rdata and data_rdata are driven by mem_rdata and are meaningful only when the matching data_ok=1.

Decomposition:
- Shared package/header: state encodings (ARB_IDLE/ARB_REQ/ARB_WAIT), owner encodings (OWN_INST/OWN_DATA), and size encodings (SIZE_B/H/W).
- One sub-module, sram_req_mux: the combinational owner-select of the request payload plus the addr_ok/data_ok demux. The FSM stays in the top module.

Test Plan:
- Single load: data_req=1, addr=0x1000, wr=0, size=2, with mem_addr_ok the cycle after grant and mem_data_ok 2 cycles later with rdata 0xDEADBEEF. Expect data_addr_ok pulse, then data_data_ok=1 with data_rdata=0xDEADBEEF, and inst_* stay 0.
- Collision: inst_req and data_req asserted in the same cycle (store to 0x2000, wstrb=0011, wdata=0x1234). Expect the data store issued first with mem_wstrb=0011, then the inst read of inst_addr issued after the state returns to IDLE.
- Flush in WAIT: inst fetch at 0xBFC00000 accepted, flush pulses, then mem_data_ok arrives. Expect inst_data_ok=0 throughout, state back in IDLE, and the next inst_req served normally.
- Flush in REQ with memory stalling addr_ok for 3 cycles: mem_req held high until addr_ok, inst_addr_ok never asserted, and the response discarded.
- Flush and mem_data_ok coincide on a data load: data_data_ok=1 and the load data is delivered.
- Reset mid-WAIT: reset=0 for 1 cycle. Expect all outputs 0 next cycle, and a stray mem_data_ok afterwards produces no data_ok.
